// File: rtl/dpram_be_param.sv
// ============================================================================
// Module      : dpram_be_param
// Description : True dual-port RAM with per-byte write enables, collision
//               arbitration (port A wins), optional output register and a
//               post-reset clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dpram_be_param #(
  parameter int AW       = 11,
  parameter int BYTES    = 2,
  parameter int RDW_MODE = 0,
  parameter int OREG     = 0,
  parameter int CLEAR    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wren_a,
  input  logic [BYTES-1:0]   byteena_a,
  input  logic [AW-1:0]      address_a,
  input  logic [8*BYTES-1:0] data_a,
  output logic [8*BYTES-1:0] q_a,
  input  logic               wren_b,
  input  logic [BYTES-1:0]   byteena_b,
  input  logic [AW-1:0]      address_b,
  input  logic [8*BYTES-1:0] data_b,
  output logic [8*BYTES-1:0] q_b,
  output logic               busy,
  output logic               collision
);

  localparam int DW    = 8 * BYTES;
  localparam int DEPTH = 2 ** AW;

  localparam logic [0:0] ST_CLR = 1'b0;
  localparam logic [0:0] ST_RDY = 1'b1;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_busy;
  logic             r_collision;
  logic [DW-1:0]    r_q1_a;
  logic [DW-1:0]    r_q1_b;
  logic             w_rdy;
  logic [BYTES-1:0] w_we_a;
  logic [BYTES-1:0] w_we_b;
  logic [DW-1:0]    w_rd_a;
  logic [DW-1:0]    w_rd_b;

  assign w_rdy  = (r_state == ST_RDY);
  assign w_we_a = {BYTES{wren_a & w_rdy}} & byteena_a;
  assign w_we_b = {BYTES{wren_b & w_rdy}} & byteena_b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= (CLEAR != 0) ? ST_CLR : ST_RDY;
      r_clr_cnt <= '0;
      r_busy    <= (CLEAR != 0);
    end else if (r_state == ST_CLR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == {AW{1'b1}}) begin
        r_state <= ST_RDY;
        r_busy  <= 1'b0;
      end
    end
  end

  // Port B lanes are scheduled first so port A's later assignment wins overlaps
  always_ff @(posedge clock) begin
    if (!w_rdy) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_we_b[i]) r_mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
        if (w_we_a[i]) r_mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_rd_a = r_mem[address_a];
    w_rd_b = r_mem[address_b];
    if (RDW_MODE != 0) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_we_a[i]) w_rd_a[8*i +: 8] = data_a[8*i +: 8];
        if (w_we_b[i]) w_rd_b[8*i +: 8] = data_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q1_a      <= '0;
      r_q1_b      <= '0;
      r_collision <= 1'b0;
    end else begin
      r_q1_a      <= w_rdy ? w_rd_a : '0;
      r_q1_b      <= w_rdy ? w_rd_b : '0;
      r_collision <= w_rdy && wren_a && wren_b && (address_a == address_b)
                     && ((byteena_a & byteena_b) != '0);
    end
  end

  generate
    if (OREG != 0) begin : g_oreg_on
      logic [DW-1:0] r_q2_a;
      logic [DW-1:0] r_q2_b;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_q2_a <= '0;
          r_q2_b <= '0;
        end else begin
          r_q2_a <= w_rdy ? r_q1_a : '0;
          r_q2_b <= w_rdy ? r_q1_b : '0;
        end
      end

      assign q_a = r_q2_a;
      assign q_b = r_q2_b;
    end else begin : g_oreg_off
      assign q_a = r_q1_a;
      assign q_b = r_q1_b;
    end
  endgenerate

  assign busy      = r_busy;
  assign collision = r_collision;

endmodule

`default_nettype wire
